// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode constants, ALU op encodings,
// the zero-register index, the control bundle carried into ID/EX, and a
// helper that classifies a fetched instruction.
package legv8_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_t;

  typedef enum logic [2:0] {
    K_NOP,
    K_RTYPE,
    K_LDUR,
    K_STUR,
    K_CBZ,
    K_B,
    K_ILLEGAL
  } instr_kind_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_t alu_op;
    logic    cbz;
    logic    b;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

  // All-zero is the IF/ID reset value and decodes as a harmless NOP.
  function automatic instr_kind_t classify(input logic [31:0] instr);
    instr_kind_t k;
    k = K_ILLEGAL;
    if (instr == '0)
      k = K_NOP;
    else if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
             instr[31:21] == OP_AND || instr[31:21] == OP_ORR)
      k = K_RTYPE;
    else if (instr[31:21] == OP_LDUR)
      k = K_LDUR;
    else if (instr[31:21] == OP_STUR)
      k = K_STUR;
    else if (instr[31:24] == OP_CBZ)
      k = K_CBZ;
    else if (instr[31:26] == OP_B)
      k = K_B;
    return k;
  endfunction

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// register_file: NREGS x XLEN general-purpose registers.
// Ports: clock/reset (sync, active-high, clears all entries); two
// combinational read ports (raddr1/rdata1, raddr2/rdata2); one write port
// (wen, waddr, wdata) committed on the rising edge. The top index is the
// zero register: it always reads 0 and ignores writes. A read of the
// register being written this cycle returns the incoming write data.
module register_file #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     wen,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZR = AW'(NREGS - 1);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wen && waddr != ZR) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != ZR) rdata1 = (wen && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != ZR) rdata2 = (wen && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: LEGv8 ID stage, consumer of the IF/ID register.
// Inputs: IF/ID instruction and PC+4, WB write port (wb_reg_write/wb_rd/
// wb_data), flush from branch resolution. Outputs: combinational pc_wren and
// if_id_wren (low during a load-use stall), and the ID/EX pipeline register
// (id_ex_*) holding operands, sign-extended immediate, register indices and
// control. Stalls, flushes, NOPs and illegal opcodes load a zeroed bubble;
// id_ex_illegal marks a bubble caused by an undecodable instruction.
module instruction_decode_stage
  import legv8_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     if_id_instruction,
  input  logic [XLEN-1:0] if_id_pc_inc,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            pc_wren,
  output logic            if_id_wren,
  output logic [XLEN-1:0] id_ex_pc_inc,
  output logic [XLEN-1:0] id_ex_rdata1,
  output logic [XLEN-1:0] id_ex_rdata2,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd,
  output logic [4:0]      id_ex_rn,
  output logic [4:0]      id_ex_rm,
  output logic [3:0]      id_ex_alu_op,
  output logic            id_ex_alu_src,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_mem_to_reg,
  output logic            id_ex_cbz,
  output logic            id_ex_b,
  output logic            id_ex_illegal
);
  logic [31:0]     instr;
  instr_kind_t     kind;
  ctrl_t           ctrl;
  logic [4:0]      rn, src2, rd;
  logic [XLEN-1:0] imm, rdata1, rdata2;
  logic            uses_rn, uses_src2, hazard, stall, bubble;

  assign instr = if_id_instruction;
  assign rn    = instr[9:5];
  assign rd    = instr[4:0];

  always_comb begin
    kind      = classify(instr);
    ctrl      = CTRL_BUBBLE;
    imm       = '0;
    uses_rn   = 1'b0;
    uses_src2 = 1'b0;
    src2      = instr[20:16];
    case (kind)
      K_RTYPE: begin
        ctrl.reg_write = 1'b1;
        uses_rn        = 1'b1;
        uses_src2      = 1'b1;
        case (instr[31:21])
          OP_SUB:  ctrl.alu_op = ALU_SUB;
          OP_AND:  ctrl.alu_op = ALU_AND;
          OP_ORR:  ctrl.alu_op = ALU_ORR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      K_LDUR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        uses_rn         = 1'b1;
        imm             = {{(XLEN-9){instr[20]}}, instr[20:12]};
      end
      K_STUR: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        uses_rn        = 1'b1;
        uses_src2      = 1'b1;
        src2           = instr[4:0];
        imm            = {{(XLEN-9){instr[20]}}, instr[20:12]};
      end
      K_CBZ: begin
        ctrl.cbz    = 1'b1;
        ctrl.alu_op = ALU_PASSB;
        uses_src2   = 1'b1;
        src2        = instr[4:0];
        imm         = {{(XLEN-19){instr[23]}}, instr[23:5]};
      end
      K_B: begin
        ctrl.b = 1'b1;
        imm    = {{(XLEN-26){instr[25]}}, instr[25:0]};
      end
      default: ;
    endcase
  end

  register_file #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_register_file (
    .clock (clock),
    .reset (reset),
    .raddr1(rn),
    .raddr2(src2),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .wen   (wb_reg_write),
    .waddr (wb_rd),
    .wdata (wb_data)
  );

  // Load-use check against the instruction now sitting in ID/EX. The
  // inserted bubble clears id_ex_mem_read, so a stall lasts one cycle.
  assign hazard = id_ex_mem_read && id_ex_rd != XZR &&
                  ((uses_rn && id_ex_rd == rn) || (uses_src2 && id_ex_rd == src2));
  assign stall      = hazard && !flush;
  assign pc_wren    = !stall;
  assign if_id_wren = !stall;

  assign bubble = flush || stall || kind == K_NOP || kind == K_ILLEGAL;

  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      id_ex_pc_inc     <= '0;
      id_ex_rdata1     <= '0;
      id_ex_rdata2     <= '0;
      id_ex_imm        <= '0;
      id_ex_rd         <= '0;
      id_ex_rn         <= '0;
      id_ex_rm         <= '0;
      id_ex_alu_op     <= '0;
      id_ex_alu_src    <= 1'b0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      id_ex_mem_write  <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_cbz        <= 1'b0;
      id_ex_b          <= 1'b0;
      id_ex_illegal    <= !reset && !flush && kind == K_ILLEGAL;
    end else begin
      id_ex_pc_inc     <= if_id_pc_inc;
      id_ex_rdata1     <= rdata1;
      id_ex_rdata2     <= rdata2;
      id_ex_imm        <= imm;
      id_ex_rd         <= rd;
      id_ex_rn         <= rn;
      id_ex_rm         <= src2;
      id_ex_alu_op     <= ctrl.alu_op;
      id_ex_alu_src    <= ctrl.alu_src;
      id_ex_reg_write  <= ctrl.reg_write;
      id_ex_mem_read   <= ctrl.mem_read;
      id_ex_mem_write  <= ctrl.mem_write;
      id_ex_mem_to_reg <= ctrl.mem_to_reg;
      id_ex_cbz        <= ctrl.cbz;
      id_ex_b          <= ctrl.b;
      id_ex_illegal    <= 1'b0;
    end
  end

endmodule
